// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the rgb444 pixel type for the VGA scan path.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam logic        SYNC_ACT = 1'b0;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Eight vertical bars; bar k lights r/g/b from bits 2/1/0 of k.
    function automatic rgb444_t test_bar(input logic [9:0] h, input logic [9:0] bar_w);
        logic [2:0] k;
        k = 3'(h / bar_w);
        return '{r: {4{k[2]}}, g: {4{k[1]}}, b: {4{k[0]}}};
    endfunction

endpackage

// File: rtl/pix_en_div.sv
// Clock-enable divider: one-clk pix_en strobe every DIV system clocks, first strobe DIV clks after reset.
module pix_en_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Strobe is registered from the next count so it is high exactly while cnt == DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pix_en <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pix_en <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator with registered, blanked colour and sync pins.
// Define VGA_TEST_PATTERN_EN to replace r_in/g_in/b_in with 8 vertical colour bars.
module vga_scan_gen #(
    parameter int unsigned CLK_DIV  = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter logic        SYNC_ACT = vga_timing_pkg::SYNC_ACT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       pix_en,
    output logic       frame_start,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    import vga_timing_pkg::*;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);

    logic    hs_raw;
    logic    vs_raw;
    rgb444_t pix_rgb;
    rgb444_t rgb_q;

    pix_en_div #(.DIV(CLK_DIV)) u_pix_en_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign valid       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_start = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign hs_raw      = (h_cnt >= HS_BEGIN) && (h_cnt < HS_STOP);
    assign vs_raw      = (v_cnt >= VS_BEGIN) && (v_cnt < VS_STOP);

`ifdef VGA_TEST_PATTERN_EN
    assign pix_rgb = test_bar(h_cnt, BAR_W);
`else
    assign pix_rgb = '{r: r_in, g: g_in, b: b_in};
`endif

    // Colour and sync share one register stage so both lag the counters by one pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q  <= '0;
            vga_hs <= ~SYNC_ACT;
            vga_vs <= ~SYNC_ACT;
        end else if (pix_en) begin
            rgb_q  <= valid ? pix_rgb : '0;
            vga_hs <= hs_raw ? SYNC_ACT : ~SYNC_ACT;
            vga_vs <= vs_raw ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: full-size line timing plus a shrunken raster for frame wrap.
module tb_vga_scan_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] r_in = '0, g_in = '0, b_in = '0;
    logic [9:0] h_cnt, v_cnt;
    logic       valid, pix_en, frame_start, vga_hs, vga_vs;
    logic [3:0] vga_r, vga_g, vga_b;

    logic [3:0] s_r = 4'hf, s_g = 4'hf, s_b = 4'hf;
    logic [9:0] s_h, s_v;
    logic       s_valid, s_pix_en, s_fs, s_hs, s_vs;
    logic [3:0] s_vr, s_vg, s_vb;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    int main_fs  = 0;
    int s_fs_cnt = 0;
    int fs_h     = -1;
    int fs_v     = -1;

    always #5 clk = ~clk;

    vga_scan_gen u_dut (
        .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .pix_en(pix_en),
        .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    // Shrunken raster: 24 x 10 total, 16 x 6 visible, active-high sync.
    vga_scan_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .r_in(s_r), .g_in(s_g), .b_in(s_b),
        .h_cnt(s_h), .v_cnt(s_v), .valid(s_valid), .pix_en(s_pix_en),
        .frame_start(s_fs), .vga_r(s_vr), .vga_g(s_vg), .vga_b(s_vb),
        .vga_hs(s_hs), .vga_vs(s_vs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inputs;
        case (mode)
            1: begin r_in = (h_cnt == 10'd0) ? 4'hf : 4'h0; g_in = '0; b_in = '0; end
            2: begin r_in = 4'hf; g_in = 4'hf; b_in = 4'hf; end
            default: begin r_in = '0; g_in = '0; b_in = '0; end
        endcase
    endtask

    task automatic next_pix;
        int n = 0;
        while (pix_en !== 1'b1) begin
            if (n == 8) begin
                $display("FAIL pix_en_timeout: no strobe within %0d clks", n);
                $fatal(1);
            end
            tick();
            n++;
        end
        if (frame_start === 1'b1) main_fs++;
        tick();
        apply_inputs();
    endtask

    task automatic next_pix_s;
        int n = 0;
        while (s_pix_en !== 1'b1) begin
            if (n == 4) begin
                $display("FAIL s_pix_en_timeout: no strobe within %0d clks", n);
                $fatal(1);
            end
            tick();
            n++;
        end
        if (s_fs === 1'b1) begin
            s_fs_cnt++;
            fs_h = int'(s_h);
            fs_v = int'(s_v);
        end
        tick();
    endtask

    initial begin
        int hs_low, first_hs, vs_low, r_bad, act_bad, ph, pv;
        int s_vs_cnt, s_hs_cnt, fvh, fvv, blank_bad, act_fff;

`ifdef VGA_TEST_PATTERN_EN
        mode = 2;
`else
        mode = 1;
`endif
        apply_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_h_cnt", h_cnt, 0);
        check("rst_v_cnt", v_cnt, 0);
        check("rst_valid", valid, 1);
        check("rst_pix_en", pix_en, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_small_hs", s_hs, 0);

        @(negedge clk) rst = 1'b0;
        tick();
        tick();
        check("pix_en_early", pix_en, 0);
        tick();
        check("first_pix_en", pix_en, 1);
        check("h_before_first_pix", h_cnt, 0);
        tick();
        check("h_after_first_pix", h_cnt, 1);
        check("pix_en_one_clk", pix_en, 0);
`ifdef VGA_TEST_PATTERN_EN
        check("bar0_h0", {vga_r, vga_g, vga_b}, 12'h000);
`else
        check("r_at_h0", vga_r, 4'hf);
`endif
        apply_inputs();

        hs_low = 0; first_hs = -1; vs_low = 0; r_bad = 0;
        for (int i = 0; i < 799; i++) begin
            ph = int'(h_cnt);
            next_pix();
            if (vga_hs == 1'b0) begin
                if (hs_low == 0) first_hs = ph;
                hs_low++;
            end
            if (vga_vs == 1'b0) vs_low++;
`ifdef VGA_TEST_PATTERN_EN
            if (ph == 80)  check("bar1_h80", {vga_r, vga_g, vga_b}, 12'h00f);
            if (ph == 560) check("bar7_h560", {vga_r, vga_g, vga_b}, 12'hfff);
            if (ph == 640) check("bar_blank_h640", {vga_r, vga_g, vga_b}, 12'h000);
`else
            if (vga_r != 4'h0) r_bad++;
`endif
        end
        check("line_wrap_h", h_cnt, 0);
        check("line_wrap_v", v_cnt, 1);
        check("hs_width", hs_low, 96);
        check("hs_start_after_h", first_hs, 656);
        check("vs_idle_line0", vs_low, 0);
`ifndef VGA_TEST_PATTERN_EN
        check("r_only_at_h0", r_bad, 0);
`endif

        next_pix();
`ifdef VGA_TEST_PATTERN_EN
        check("bar0_line1", {vga_r, vga_g, vga_b}, 12'h000);
`else
        check("r_line1_h0", vga_r, 4'hf);
`endif
        mode = 2;
        apply_inputs();
        act_bad = 0;
        for (int i = 0; i < 799; i++) begin
            ph = int'(h_cnt);
            next_pix();
            if (h_cnt == 10'd639) check("valid_h639", valid, 1);
            if (h_cnt == 10'd640) check("valid_h640", valid, 0);
            if (ph == 639) check("fff_h639", {vga_r, vga_g, vga_b}, 12'hfff);
            if (ph == 640) check("blank_h640", {vga_r, vga_g, vga_b}, 12'h000);
            if (ph >= 640 && {vga_r, vga_g, vga_b} != 12'h000) act_bad++;
`ifndef VGA_TEST_PATTERN_EN
            if (ph < 640 && {vga_r, vga_g, vga_b} != 12'hfff) act_bad++;
`endif
        end
        check("line1_rgb_rule", act_bad, 0);
        check("line2_v", v_cnt, 2);
        check("no_frame_start_main", main_fs, 0);

        repeat (100) next_pix();
        check("rgb_before_async_rst", ({vga_r, vga_g, vga_b} != 12'h000), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_h", h_cnt, 0);
        check("async_rst_v", v_cnt, 0);
        check("async_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("async_rst_pix_en", pix_en, 0);

        repeat (2) @(posedge clk);
        #1;
        check("s_rst_vs", s_vs, 0);
        check("s_rst_h", s_h, 0);
        @(negedge clk) rst = 1'b0;
        #1;
        s_vs_cnt = 0; s_hs_cnt = 0; fvh = -1; fvv = -1; blank_bad = 0; act_fff = 0;
        for (int i = 0; i < 240; i++) begin
            ph = int'(s_h);
            pv = int'(s_v);
            next_pix_s();
            if (s_vs == 1'b1) begin
                if (s_vs_cnt == 0) begin fvh = ph; fvv = pv; end
                s_vs_cnt++;
            end
            if (s_hs == 1'b1) s_hs_cnt++;
            if (ph < 16 && pv < 6) begin
                if ({s_vr, s_vg, s_vb} == 12'hfff) act_fff++;
            end else if ({s_vr, s_vg, s_vb} != 12'h000) begin
                blank_bad++;
            end
        end
        check("s_frame_start_count", s_fs_cnt, 1);
        check("s_frame_start_h", fs_h, 23);
        check("s_frame_start_v", fs_v, 9);
        check("s_wrap_h", s_h, 0);
        check("s_wrap_v", s_v, 0);
        check("s_vs_width", s_vs_cnt, 48);
        check("s_vs_start_v", fvv, 7);
        check("s_vs_start_h", fvh, 0);
        check("s_hs_total", s_hs_cnt, 40);
        check("s_blanking", blank_bad, 0);
`ifdef VGA_TEST_PATTERN_EN
        check("s_bar7_count", act_fff, 12);
`else
        check("s_active_fff", act_fff, 96);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Display-side counterpart of the per-screen pixel generators such as the song-select renderer.
- Generates the 640x480@60 raster: h_cnt, v_cnt and valid, which feed every pixel generator.
- Takes back the generator's combinational r/g/b for the current (h_cnt, v_cnt) and registers it, together with hsync/vsync, to the board VGA pins.
- Sits between the top-level screen mux and the VGA connector.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_ACT, 0: asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- r_in  in  4  red from the pixel generator (combinational of h_cnt/v_cnt).
- g_in  in  4  green from the pixel generator.
- b_in  in  4  blue from the pixel generator.
- h_cnt  out  10  current column, 0..H_TOTAL-1.
- v_cnt  out  10  current line, 0..V_TOTAL-1.
- valid  out  1  high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- pix_en  out  1  one-clk strobe, every CLK_DIV clks.
- frame_start  out  1  one-clk pulse when the raster wraps to (0,0).
- vga_r  out  4  registered red to the pins.
- vga_g  out  4  registered green to the pins.
- vga_b  out  4  registered blue to the pins.
- vga_hs  out  1  registered horizontal sync.
- vga_vs  out  1  registered vertical sync.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525. All counter arithmetic is 10-bit unsigned.
- Reset (async, immediate):
  - divider = 0, h_cnt = 0, v_cnt = 0.
  - pix_en = 0, frame_start = 0.
  - vga_r/g/b = 0; vga_hs = vga_vs = ~SYNC_ACT.
  - valid follows the counters, so it is 1 during reset (0,0). Downstream outputs stay blanked through the registers.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en is high during the clk in which the divider equals CLK_DIV-1.
  - The first pix_en occurs CLK_DIV clks after reset release.
- Counters advance only on pix_en:
  - h_cnt == H_TOTAL-1 -> h_cnt wraps to 0 and v_cnt increments.
  - v_cnt == V_TOTAL-1 at the same time -> v_cnt wraps to 0.
  - frame_start is asserted for that single clk, coincident with pix_en.
- Sync decode is combinational on the counters:
  - hs_raw active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw active while 490 <= v_cnt < 492.
- Output stage, updated only on pix_en:
  - vga_rgb <= valid ? {r_in,g_in,b_in} : 0.
  - vga_hs <= hs_raw ? SYNC_ACT : ~SYNC_ACT; vga_vs is encoded the same way.
  - Latency from counter value to pins is exactly 1 pixel period, equal for colour and sync, so they stay aligned.
- Blanking overrides the generator: nonzero r_in while valid=0 never reaches the pins.
- Reset mid-frame restarts at (0,0) with blank outputs. No partial-frame pulse is generated.

Optional Feature:
- VGA_TEST_PATTERN_EN defined:
  - r_in/g_in/b_in are ignored.
  - Active area shows 8 vertical colour bars, each H_ACTIVE/8 = 80 px wide.
  - Bar index = h_cnt[9:0]/80; bar k drives r = {4{k[2]}}, g = {4{k[1]}}, b = {4{k[0]}}.
  - Timing and latency are identical to normal mode.
- Undefined: normal pass-through of r_in/g_in/b_in.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the timing constants and derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a 12-bit rgb444 typedef.
- One sub-module, pix_en_div: parameterised clock-enable divider producing pix_en.

Test Plan:
- Assert rst for 3 clks, release -> all outputs hold reset values; first pix_en 4 clks later; h_cnt = 1 on the following clk.
- Run 3200 clks (one line) -> h_cnt returns to 0 and v_cnt = 1; vga_hs active for exactly 96 pix_en ticks, starting on the tick after h_cnt == 656.
- Run one full frame of 1,680,000 clks -> exactly one frame_start pulse at the (524,799) -> (0,0) wrap; vga_vs active for 2 lines, starting after v_cnt == 490.
- Drive r_in = f only when h_cnt == 0 -> vga_r = f during the pixel period following h_cnt == 0, and 0 elsewhere.
- Drive r_in/g_in/b_in = fff constantly -> pins read 0 for h_cnt >= 640 or v_cnt >= 480, and fff inside the active area.
- With VGA_TEST_PATTERN_EN: pixel at h_cnt = 0 shows rgb = 000, h_cnt = 80 shows 00f, h_cnt = 560 shows fff.
